chunked_add_sequencer: RTL and testbench

Multi-cycle wide adder controller. It adds two W-bit operands by time-multiplexing one M-bit ripple-carry adder over W/M consecutive cycles, least-significant chunk first, with the carry registered between chunks. It sits between a valid/ready operand producer and a valid/ready result consumer. It is used wherever a full-width ripple chain is too slow or too large for the clock target.

---
 rtl/adder_pkg.sv | 16 +
 rtl/ripple_adder.sv | 23 ++
 rtl/chunked_add_sequencer.sv | 104 ++++++++++
 tb/tb_chunked_add_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked adder sequencer.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Chunk counter width; a single-chunk configuration still needs one bit.
    function automatic int cnt_width(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/ripple_adder.sv
// Plain m-bit ripple-carry adder used as the shared chunk datapath.
module ripple_adder #(
    parameter int m = 8
) (
    output logic [m-1:0] sum,
    output logic         cout,
    input  logic [m-1:0] a,
    input  logic [m-1:0] b,
    input  logic         cin
);

    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < m; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/chunked_add_sequencer.sv
// Wide adder that reuses one M-bit ripple adder over W/M cycles, LSB chunk first,
// between a valid/ready operand source and a valid/ready result sink.
module chunked_add_sequencer
    import adder_pkg::*;
#(
    parameter int W = 32,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int N  = W / M;
    localparam int CW = cnt_width(N);

    state_t         state, next_state;
    logic [W-1:0]   op_a, op_b, result, result_next;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic [M-1:0]   chunk_sum;
    logic           chunk_cout;
    logic           last_chunk;

    assign last_chunk = (cnt == CW'(N - 1));

    ripple_adder #(.m(M)) u_chunk_adder (
        .sum  (chunk_sum),
        .cout (chunk_cout),
        .a    (op_a[M-1:0]),
        .b    (op_b[M-1:0]),
        .cin  (carry)
    );

    // New chunk enters at the MSB end so the final chunk lands in the top slice.
    generate
        if (N == 1) begin : g_single
            assign result_next = chunk_sum;
        end else begin : g_multi
            assign result_next = {chunk_sum, result[W-1:M]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)   next_state = RUN;
            RUN:     if (last_chunk) next_state = DONE;
            DONE:    if (out_ready)  next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a   <= op_a >> M;
                    op_b   <= op_b >> M;
                    result <= result_next;
                    carry  <= chunk_cout;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs come straight from state and data registers only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = result;
    assign cout      = carry;

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Randomized and directed bench for chunked_add_sequencer at W32/M8, W16/M4 and W8/M8.
module tb_chunked_add_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        m_in_valid, m_in_ready, m_cin, m_out_valid, m_out_ready, m_cout, m_busy;
    logic [31:0] m_a, m_b, m_sum;
    logic        s16_in_valid, s16_in_ready, s16_cin, s16_out_valid, s16_out_ready, s16_cout, s16_busy;
    logic [15:0] s16_a, s16_b, s16_sum;
    logic        s8_in_valid, s8_in_ready, s8_cin, s8_out_valid, s8_out_ready, s8_cout, s8_busy;
    logic [7:0]  s8_a, s8_b, s8_sum;

    int vectors = 0;
    int miscompares = 0;

    chunked_add_sequencer #(.W(32), .M(8)) dut_main (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .a(m_a), .b(m_b), .cin(m_cin), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .sum(m_sum), .cout(m_cout), .busy(m_busy)
    );

    chunked_add_sequencer #(.W(16), .M(4)) dut_w16 (
        .clk(clk), .rst(rst), .in_valid(s16_in_valid), .in_ready(s16_in_ready),
        .a(s16_a), .b(s16_b), .cin(s16_cin), .out_valid(s16_out_valid), .out_ready(s16_out_ready),
        .sum(s16_sum), .cout(s16_cout), .busy(s16_busy)
    );

    chunked_add_sequencer #(.W(8), .M(8)) dut_w8 (
        .clk(clk), .rst(rst), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
        .a(s8_a), .b(s8_b), .cin(s8_cin), .out_valid(s8_out_valid), .out_ready(s8_out_ready),
        .sum(s8_sum), .cout(s8_cout), .busy(s8_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one operand set to the 32-bit instance with out_ready high and returns what it produced.
    task automatic main_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                           output int lat, output logic [31:0] s, output logic co);
        m_a = av; m_b = bv; m_cin = cv; m_in_valid = 1'b1; m_out_ready = 1'b1;
        tick;
        m_in_valid = 1'b0;
        lat = 0;
        while (m_out_valid !== 1'b1 && lat < 40) begin
            tick;
            lat++;
        end
        s = m_sum;
        co = m_cout;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        m_in_valid = 0; m_a = '0; m_b = '0; m_cin = 0; m_out_ready = 0;
        s16_in_valid = 0; s16_a = '0; s16_b = '0; s16_cin = 0; s16_out_ready = 0;
        s8_in_valid = 0; s8_a = '0; s8_b = '0; s8_cin = 0; s8_out_ready = 0;
        tick;
        tick;
        vectors++;
        if ({m_in_ready, m_out_valid, m_busy, m_cout} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl got rdy/vld/busy/cout=%b required 1000", {m_in_ready, m_out_valid, m_busy, m_cout});
        end
        vectors++;
        if (m_sum !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_sum got %h required 00000000", m_sum);
        end
        vectors++;
        if ({s16_in_ready, s16_out_valid, s8_in_ready, s8_out_valid} !== 4'b1010) begin
            miscompares++;
            $display("FAIL reset_small got %b required 1010", {s16_in_ready, s16_out_valid, s8_in_ready, s8_out_valid});
        end
        rst = 1'b0;
        tick;
        vectors++;
        if ({m_in_ready, m_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL post_reset_idle got rdy/busy=%b required 10", {m_in_ready, m_busy});
        end
    endtask

    task automatic test_carry_chain;
        int lat; logic [31:0] s; logic co;
        main_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, s, co);
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL carry_latency got %0d required 4", lat);
        end
        vectors++;
        if ({co, s} !== 33'h1_0000_0000) begin
            miscompares++;
            $display("FAIL carry_result got %b_%h required 1_00000000", co, s);
        end
        vectors++;
        if ({m_out_valid, m_in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL carry_return_idle got vld/rdy=%b required 01", {m_out_valid, m_in_ready});
        end
    endtask

    task automatic test_carry_in;
        int lat; logic [31:0] s; logic co;
        main_op(32'h1234_5678, 32'h1111_1111, 1'b1, lat, s, co);
        vectors++;
        if ({co, s} !== 33'h0_2345_678A) begin
            miscompares++;
            $display("FAIL cin_result got %b_%h required 0_2345678a", co, s);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        m_a = 32'h8000_0000; m_b = 32'h8000_0000; m_cin = 0; m_in_valid = 1; m_out_ready = 0;
        tick;
        m_a = 32'hDEAD_BEEF; m_b = 32'h0BAD_F00D; m_cin = 1;
        vectors++;
        if (m_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready_run got %b required 0", m_in_ready);
        end
        lat = 0;
        while (m_out_valid !== 1'b1 && lat < 40) begin
            tick;
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({m_out_valid, m_in_ready, m_cout, m_sum} !== {3'b101, 32'h0}) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d got vld/rdy/cout=%b sum=%h required 101 00000000",
                         i, {m_out_valid, m_in_ready, m_cout}, m_sum);
            end
            tick;
        end
        m_in_valid = 0;
        m_out_ready = 1;
        tick;
        vectors++;
        if ({m_out_valid, m_in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release got vld/rdy=%b required 01", {m_out_valid, m_in_ready});
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] s; logic co;
        m_a = 32'h1234_5678; m_b = 32'h1111_1111; m_cin = 0; m_in_valid = 1; m_out_ready = 1;
        tick;
        m_in_valid = 0;
        tick;
        rst = 1'b1;
        #1;
        vectors++;
        if ({m_in_ready, m_out_valid, m_busy, m_cout, m_sum} !== {4'b1000, 32'h0}) begin
            miscompares++;
            $display("FAIL midrun_reset got rdy/vld/busy/cout=%b sum=%h required 1000 00000000",
                     {m_in_ready, m_out_valid, m_busy, m_cout}, m_sum);
        end
        tick;
        rst = 1'b0;
        tick;
        main_op(32'd3, 32'd4, 1'b0, lat, s, co);
        vectors++;
        if (lat !== 4 || {co, s} !== 33'd7) begin
            miscompares++;
            $display("FAIL after_reset_op got lat=%0d result=%b_%h required lat=4 0_00000007", lat, co, s);
        end
    endtask

    task automatic test_back_to_back;
        int acc_t[$];
        logic [32:0] res[$];
        m_a = 32'h0000_FFFF; m_b = 32'h0000_0001; m_cin = 0; m_in_valid = 1; m_out_ready = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (m_in_valid && m_in_ready) acc_t.push_back(cyc);
            if (m_out_valid && m_out_ready) res.push_back({m_cout, m_sum});
            tick;
            if (acc_t.size() == 1) begin
                m_a = 32'hAAAA_AAAA; m_b = 32'h5555_5555;
            end else if (acc_t.size() >= 2) begin
                m_in_valid = 0; m_a = $urandom; m_b = $urandom; m_cin = 1;
            end
        end
        vectors++;
        if (acc_t.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_accepts got %0d required 2", acc_t.size());
        end else begin
            vectors++;
            if (acc_t[1] - acc_t[0] != 6) begin
                miscompares++;
                $display("FAIL b2b_spacing got %0d required 6", acc_t[1] - acc_t[0]);
            end
        end
        vectors++;
        if (res.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_results got %0d required 2", res.size());
        end else begin
            vectors++;
            if (res[0] !== 33'h0_0001_0000) begin
                miscompares++;
                $display("FAIL b2b_op1 got %h required 000010000", res[0]);
            end
            vectors++;
            if (res[1] !== 33'h0_FFFF_FFFF) begin
                miscompares++;
                $display("FAIL b2b_op2 got %h required 0ffffffff", res[1]);
            end
        end
        m_in_valid = 0;
    endtask

    task automatic test_random_w16(input int count);
        logic [15:0] av, bv; logic cv; logic [16:0] exp; int lat; int k;
        for (int n = 0; n < count; n++) begin
            av = 16'($urandom); bv = 16'($urandom); cv = 1'($urandom_range(0, 1));
            exp = {1'b0, av} + {1'b0, bv} + 17'(cv);
            s16_a = av; s16_b = bv; s16_cin = cv; s16_in_valid = 1; s16_out_ready = 0;
            tick;
            s16_in_valid = 0; s16_a = 16'($urandom); s16_b = 16'($urandom);
            lat = 0;
            while (s16_out_valid !== 1'b1 && lat < 20) begin
                tick;
                lat++;
            end
            vectors++;
            if (lat !== 4 || {s16_cout, s16_sum} !== exp) begin
                miscompares++;
                $display("FAIL w16_rand #%0d got lat=%0d %h required lat=4 %h", n, lat, {s16_cout, s16_sum}, exp);
            end
            k = 0;
            do begin
                s16_out_ready = (k >= 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
                tick;
                k++;
                if (!s16_out_ready) begin
                    vectors++;
                    if (s16_out_valid !== 1'b1 || {s16_cout, s16_sum} !== exp) begin
                        miscompares++;
                        $display("FAIL w16_hold #%0d got vld=%b %h required 1 %h", n, s16_out_valid, {s16_cout, s16_sum}, exp);
                    end
                end
            end while (!s16_out_ready);
            vectors++;
            if (s16_out_valid !== 1'b0 || s16_in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL w16_complete #%0d got vld/rdy=%b%b required 01", n, s16_out_valid, s16_in_ready);
            end
        end
        s16_out_ready = 0;
    endtask

    task automatic test_random_w8(input int count);
        logic [7:0] av, bv; logic cv; logic [8:0] exp; int lat; int k;
        for (int n = 0; n < count; n++) begin
            av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom_range(0, 1));
            exp = {1'b0, av} + {1'b0, bv} + 9'(cv);
            s8_a = av; s8_b = bv; s8_cin = cv; s8_in_valid = 1; s8_out_ready = 0;
            tick;
            s8_in_valid = 0; s8_a = 8'($urandom); s8_b = 8'($urandom);
            lat = 0;
            while (s8_out_valid !== 1'b1 && lat < 20) begin
                tick;
                lat++;
            end
            vectors++;
            if (lat !== 1 || {s8_cout, s8_sum} !== exp) begin
                miscompares++;
                $display("FAIL w8_rand #%0d got lat=%0d %h required lat=1 %h", n, lat, {s8_cout, s8_sum}, exp);
            end
            k = 0;
            do begin
                s8_out_ready = (k >= 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
                tick;
                k++;
                if (!s8_out_ready) begin
                    vectors++;
                    if (s8_out_valid !== 1'b1 || {s8_cout, s8_sum} !== exp) begin
                        miscompares++;
                        $display("FAIL w8_hold #%0d got vld=%b %h required 1 %h", n, s8_out_valid, {s8_cout, s8_sum}, exp);
                    end
                end
            end while (!s8_out_ready);
            vectors++;
            if (s8_out_valid !== 1'b0 || s8_in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL w8_complete #%0d got vld/rdy=%b%b required 01", n, s8_out_valid, s8_in_ready);
            end
        end
        s8_out_ready = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_carry_chain;
        test_carry_in;
        test_backpressure;
        test_reset_mid;
        test_back_to_back;
        test_random_w16(5000);
        test_random_w8(5000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
